// File: rtl/nn_ahb_rd_master.sv
`default_nettype none
// ============================================================================
// Module  : nn_ahb_rd_master
// Purpose : AHB-Lite read initiator for the NN core. Fetches word_cnt words
//           from base_addr using pipelined 32-bit INCR reads. Returned words
//           are streamed to the core through a credit-protected FIFO on a
//           valid/ready port.
// Options : NN_AHBM_BYTE_SWAP_EN - byte-reverse every HRDATA word before it
//           is written to the FIFO, for big-endian weight images.
// Revision: 1.0 - initial release
// ============================================================================
module nn_ahb_rd_master #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_cnt,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [2:0]       HBURST,
    output logic [3:0]       HPROT,
    input  logic [31:0]      HRDATA,
    input  logic             HREADY,
    input  logic             HRESP
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FILL_W = PTR_W + 1;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_ERR   = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [CNT_W-1:0]   left_q, left_d;
    logic               nonseq_q, nonseq_d;
    logic               err_q, err_d;
    logic               outst_q, outst_d;

    logic [31:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wptr_q, rptr_q;
    logic [FILL_W-1:0]  count_q;

    logic               err_first;
    logic               credit_ok;
    logic               issue;
    logic               accept;
    logic               push;
    logic               pop;
    logic [31:0]        fifo_wdata;
    logic [FILL_W-1:0]  fill;

    // Credit: FIFO words held plus the beat still in its data phase must
    // leave room for one more word before a new address may be issued.
    assign fill      = count_q + FILL_W'(outst_q);
    assign credit_ok = (fill < FILL_W'(FIFO_DEPTH));
    // First cycle of a two-cycle ERROR response: any pipelined address is cancelled.
    assign err_first = outst_q && !HREADY && HRESP;
    assign issue     = (state_q == S_RUN) && (left_q != '0) && credit_ok && !err_first;
    assign accept    = issue && HREADY;
    assign push      = outst_q && HREADY && !HRESP &&
                       ((state_q == S_RUN) || (state_q == S_DRAIN));
    assign pop       = rd_valid && rd_ready;

`ifdef NN_AHBM_BYTE_SWAP_EN
    assign fifo_wdata = {HRDATA[7:0], HRDATA[15:8], HRDATA[23:16], HRDATA[31:24]};
`else
    assign fifo_wdata = HRDATA;
`endif

    assign HADDR    = addr_q;
    assign HTRANS   = !issue ? TRANS_IDLE :
                      ((nonseq_q || (addr_q[9:0] == 10'd0)) ? TRANS_NONSEQ : TRANS_SEQ);
    assign HWRITE   = 1'b0;
    assign HSIZE    = 3'b010;
    assign HBURST   = 3'b001;
    assign HPROT    = 4'b0011;

    assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_ERR);
    assign done     = (state_q == S_FIN);
    assign err      = err_q;
    assign rd_valid = (count_q != '0);
    assign rd_data  = fifo_mem[rptr_q];

    // Control state, address, beat counter and sticky error registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'd0;
            left_q   <= '0;
            nonseq_q <= 1'b1;
            err_q    <= 1'b0;
            outst_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            left_q   <= left_d;
            nonseq_q <= nonseq_d;
            err_q    <= err_d;
            outst_q  <= outst_d;
        end
    end

    // Next-state logic: job acceptance, address sequencing and termination.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        left_d   = left_q;
        nonseq_d = nonseq_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    addr_d   = base_addr & 32'hFFFF_FFFC;
                    left_d   = word_cnt;
                    nonseq_d = 1'b1;
                    err_d    = 1'b0;
                end
            end
            S_RUN: begin
                if (err_first) begin
                    state_d = S_ERR;
                end else if (accept) begin
                    addr_d   = addr_q + 32'd4;
                    left_d   = left_q - CNT_W'(1);
                    nonseq_d = 1'b0;
                    if (left_q == CNT_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    // Any IDLE cycle forces the next beat to restart as NONSEQ.
                    if (!issue) begin
                        nonseq_d = 1'b1;
                    end
                    if ((left_q == '0) && !outst_q) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_DRAIN: begin
                if (err_first) begin
                    state_d = S_ERR;
                end else if (push) begin
                    state_d = S_FIN;
                end
            end
            S_ERR: begin
                if (HREADY) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Data-phase tracking: at most one beat is ever outstanding.
    always_comb begin
        outst_d = outst_q;
        if (outst_q && HREADY) begin
            outst_d = 1'b0;
        end
        if (accept) begin
            outst_d = 1'b1;
        end
    end

    // FIFO pointers and occupancy; reset discards any held words.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            count_q <= count_q + FILL_W'(push) - FILL_W'(pop);
        end
    end

    // FIFO storage; contents are qualified by the occupancy count.
    always_ff @(posedge HCLK) begin
        if (push) begin
            fifo_mem[wptr_q] <= fifo_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nn_ahb_rd_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_nn_ahb_rd_master
// Purpose : Self-checking bench for nn_ahb_rd_master. A behavioural AHB slave
//           (memory word = address ^ 0xC0DE0000) with wait states and error
//           injection, plus a transaction-level reference of address order,
//           transfer types, FIFO contents and job completion.
// Revision: 1.0 - initial release
// ============================================================================
module tb_nn_ahb_rd_master;
    localparam int DEPTH = 8;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_cnt;
    logic        busy, done, err;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int checks   = 0;
    int failures = 0;

    nn_ahb_rd_master #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .base_addr(base_addr),
        .word_cnt(word_cnt), .busy(busy), .done(done), .err(err),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HRDATA(HRDATA), .HREADY(HREADY),
        .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [31:0] base;
        int          cnt;
        int          waits;
        int          err_beat;
        int          rmode;
        logic [31:0] exp_first;
        bit          chk_first;
        logic [15:0] exp_ns;
        bit          chk_ns;
        int          exp_beats;
        int          exp_words;
        bit          exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bs(input logic [31:0] w);
`ifdef NN_AHBM_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // One complete job against the behavioural slave. rmode: 0 ready always,
    // 1 random ready, 2 ready held low for 30 cycles.
    task automatic run_job(input logic [31:0] base, input int cnt, input int waits,
                           input int err_beat, input int rmode,
                           input logic [31:0] exp_first, input bit chk_first,
                           input logic [15:0] exp_ns, input bit chk_ns,
                           input int exp_beats, input int exp_words, input bit exp_err);
        logic [31:0] q[$];
        logic [31:0] exp_addr, got;
        logic [31:0] dp_addr;
        logic [31:0] prev_addr;
        logic [1:0]  prev_trans;
        bit          dp_valid = 0, dp_err = 0, gap = 1, prev_hold = 0, first_pop = 1;
        bit          ns_exp;
        int          dp_wait = 0, err_stage = 0;
        int          beats_acc = 0, words_cap = 0, done_cnt = 0, done_cyc = -1, last_evt = 0;
        int          cyc;
        for (cyc = 0; cyc < 3000; cyc++) begin
            @(negedge HCLK);
            start     = (cyc == 0) || (cyc == 2 && cnt >= 2);
            base_addr = (cyc == 0) ? base : 32'hDEAD_BEE0;
            word_cnt  = (cyc == 0) ? 16'(cnt) : 16'd3;
            if (done_cnt > 0 || rmode == 0) rd_ready = 1'b1;
            else if (rmode == 1)            rd_ready = 1'($urandom_range(0, 1));
            else                            rd_ready = (cyc >= 30);
            HRDATA = $urandom;
            if (dp_valid && dp_wait > 0) begin
                HREADY = 1'b0; HRESP = 1'b0;
            end else if (dp_valid && dp_err) begin
                HREADY = (err_stage == 1); HRESP = 1'b1;
            end else begin
                HREADY = 1'b1; HRESP = 1'b0;
                if (dp_valid) HRDATA = memf(dp_addr);
            end
            #1;
            if (cyc == 1) begin
                check("busy_after_start", 32'(busy), 32'd1);
                check("err_cleared_by_start", 32'(err), 32'd0);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_low_at_done", 32'(busy), 32'd0);
            end
            if (rmode == 2 && cyc == 29) begin
                check("stall_beats", 32'(beats_acc), 32'((cnt < DEPTH) ? cnt : DEPTH));
                check("stall_htrans_idle", 32'(HTRANS), 32'd0);
            end
            if (dp_valid && dp_err && dp_wait == 0 && err_stage == 0)
                check("err_cycle1_htrans_idle", 32'(HTRANS), 32'd0);
            if (prev_hold && !(HREADY == 1'b0 && HRESP == 1'b1)) begin
                check("held_htrans", 32'(HTRANS), 32'(prev_trans));
                check("held_haddr", HADDR, prev_addr);
            end
            check("rd_valid_vs_model", 32'(rd_valid), 32'(q.size() != 0));
            if (HTRANS == 2'b00) gap = 1;
            // Consumer side
            if (rd_valid && rd_ready && q.size() != 0) begin
                got = q.pop_front();
                check("rd_data", rd_data, got);
                if (first_pop && chk_first) check("first_word", rd_data, exp_first);
                first_pop = 0;
            end
            // Completing data phase
            if (dp_valid && HREADY) begin
                if (!dp_err) begin
                    q.push_back(bs(memf(dp_addr)));
                    words_cap++;
                end
                last_evt = cyc;
                dp_valid = 0;
            end else if (dp_valid && !HREADY) begin
                if (dp_wait > 0) dp_wait--;
                else if (dp_err) err_stage = 1;
            end
            // Address phase accepted at this edge
            if (HREADY && HTRANS[1]) begin
                check("beat_allowed", 32'(beats_acc < exp_beats), 32'd1);
                exp_addr = (base & 32'hFFFF_FFFC) + 32'(4 * beats_acc);
                check("haddr", HADDR, exp_addr);
                ns_exp = (beats_acc == 0) || gap || (exp_addr[9:0] == 10'd0);
                check("htrans_rule", 32'(HTRANS), ns_exp ? 32'd2 : 32'd3);
                if (chk_ns && beats_acc < 16)
                    check("htrans_table", 32'(HTRANS), exp_ns[beats_acc] ? 32'd2 : 32'd3);
                if (waits == 0 && rmode == 0)
                    check("back_to_back", 32'(cyc), 32'(beats_acc + 1));
                check("credit", 32'(q.size() + (dp_valid ? 1 : 0) < DEPTH), 32'd1);
                dp_valid  = 1;
                dp_addr   = HADDR;
                dp_wait   = waits;
                dp_err    = (beats_acc == err_beat);
                err_stage = 0;
                gap       = 0;
                beats_acc++;
            end
            prev_hold  = (HTRANS != 2'b00) && !HREADY;
            prev_trans = HTRANS;
            prev_addr  = HADDR;
            if (done_cnt > 0 && q.size() == 0 && cyc > done_cyc) break;
        end
        if (cyc >= 3000) begin
            checks++; failures++;
            $display("FAIL job_timeout actual=%0d required=<3000 cycles", cyc);
        end
        @(negedge HCLK);
        start = 1'b0; rd_ready = 1'b1; HREADY = 1'b1; HRESP = 1'b0;
        #1;
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("done_cycle", 32'(done_cyc), (cnt == 0) ? 32'd2 : 32'(last_evt + 1));
        check("beats_issued", 32'(beats_acc), 32'(exp_beats));
        check("words_captured", 32'(words_cap), 32'(exp_words));
        check("err_flag", 32'(err), 32'(exp_err));
        check("end_htrans_idle", 32'(HTRANS), 32'd0);
        check("end_rd_valid", 32'(rd_valid), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] rb;
        int          rc, re, eb, ew;
        vecs[0] = '{32'h2000_0000, 4, 0, -1, 0, bs(32'hE0DE_0000), 1, 16'h0001, 1, 4, 4, 0};
        vecs[1] = '{32'h0100_0000, 20, 0, -1, 2, bs(32'hC1DE_0000), 1, 16'h0101, 1, 20, 20, 0};
        vecs[2] = '{32'h0000_03F8, 4, 0, -1, 0, bs(32'hC0DE_03F8), 1, 16'h0005, 1, 4, 4, 0};
        vecs[3] = '{32'h4000_0000, 6, 2, 2, 0, bs(32'h80DE_0000), 1, 16'h0001, 1, 3, 2, 1};
        vecs[4] = '{32'h5000_0010, 6, 0, -1, 0, bs(32'h90DE_0010), 1, 16'h0001, 1, 6, 6, 0};
        vecs[5] = '{32'h6000_0000, 0, 0, -1, 0, 32'h0, 0, 16'h0000, 0, 0, 0, 0};
`ifdef NN_AHBM_BYTE_SWAP_EN
        vecs[6] = '{32'hD1FC_3344, 1, 0, -1, 0, 32'h4433_2211, 1, 16'h0001, 1, 1, 1, 0};
`else
        vecs[6] = '{32'hD1FC_3344, 1, 0, -1, 0, 32'h1122_3344, 1, 16'h0001, 1, 1, 1, 0};
`endif
        vecs[7] = '{32'hFFFF_FFF8, 4, 0, -1, 0, bs(32'h3F21_FFF8), 1, 16'h0005, 1, 4, 4, 0};
        vecs[8] = '{32'h7000_0000, 3, 0, 0, 0, 32'h0, 0, 16'h0001, 1, 1, 0, 1};
        vecs[9] = '{32'h0000_0FC0, 16, 1, -1, 1, bs(32'hC0DE_0FC0), 1, 16'h0000, 0, 16, 16, 0};

        HRESETn = 1'b0; start = 1'b0; base_addr = 32'h0; word_cnt = 16'h0;
        rd_ready = 1'b0; HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
        repeat (3) @(negedge HCLK);
        #1;
        check("reset_htrans", 32'(HTRANS), 32'd0);
        check("reset_haddr", HADDR, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("const_hwrite", 32'(HWRITE), 32'd0);
        check("const_hsize", 32'(HSIZE), 32'd2);
        check("const_hburst", 32'(HBURST), 32'd1);
        check("const_hprot", 32'(HPROT), 32'd3);
        @(negedge HCLK);
        HRESETn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_job(vecs[i].base, vecs[i].cnt, vecs[i].waits, vecs[i].err_beat,
                    vecs[i].rmode, vecs[i].exp_first, vecs[i].chk_first,
                    vecs[i].exp_ns, vecs[i].chk_ns, vecs[i].exp_beats,
                    vecs[i].exp_words, vecs[i].exp_err);
        end

        // Randomised jobs checked against the transaction-level model.
        for (int j = 0; j < 12; j++) begin
            rb = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 1) == 1) rb = (rb & 32'hFFFF_FC00) | 32'h0000_03E0;
            rc = $urandom_range(0, 24);
            re = -1;
            if (rc > 0 && $urandom_range(0, 3) == 0) re = $urandom_range(0, rc - 1);
            eb = (re >= 0) ? re + 1 : rc;
            ew = (re >= 0) ? re : rc;
            run_job(rb, rc, $urandom_range(0, 2), re, $urandom_range(0, 1),
                    32'h0, 0, 16'h0, 0, eb, ew, (re >= 0));
        end

        // Reset asserted in the middle of a stalled burst.
        @(negedge HCLK);
        start = 1'b1; base_addr = 32'h3000_0000; word_cnt = 16'd20;
        rd_ready = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
        @(negedge HCLK);
        start = 1'b0;
        repeat (5) @(negedge HCLK);
        #1;
        check("pre_reset_busy", 32'(busy), 32'd1);
        check("pre_reset_rd_valid", 32'(rd_valid), 32'd1);
        #2;
        HRESETn = 1'b0;
        #1;
        check("midreset_rd_valid", 32'(rd_valid), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_htrans", 32'(HTRANS), 32'd0);
        check("midreset_haddr", HADDR, 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);
        #1;
        check("post_reset_idle_htrans", 32'(HTRANS), 32'd0);
        check("post_reset_done", 32'(done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
